ibex_ifetch_bus_arbiter: RTL and testbench
==========================================

Name: ibex_ifetch_bus_arbiter

Overview:
- Shares one OBI-style memory port between the instruction prefetch path (req/gnt/rvalid, up to 2 outstanding) and the load/store unit.
- Sits between the instruction fetch stage, the LSU and the core's single external bus.
- Holds an address-phase selection stable until it is granted.
- Tracks the owner of every granted transaction so each response is routed to the requester that issued it.

Parameters:
- MaxOutstanding, 2: maximum granted-but-unanswered transactions on the bus (1..4).
- DataPriority, 1'b1: 1 = fixed priority to the data port; 0 = round-robin between the two ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch address, word aligned.
- instr_gnt_o  out  1  fetch address phase accepted.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- instr_err_o  out  1  fetch bus error.
- data_req_i  in  1  LSU request.
- data_we_i  in  1  LSU write enable.
- data_be_i  in  4  LSU byte enables.
- data_addr_i  in  32  LSU address.
- data_wdata_i  in  32  LSU write data.
- data_gnt_o  out  1  LSU address phase accepted.
- data_rvalid_o  out  1  LSU response valid.
- data_rdata_o  out  32  LSU read data.
- data_err_o  out  1  LSU bus error.
- bus_req_o  out  1  shared bus request.
- bus_we_o  out  1  shared bus write enable.
- bus_be_o  out  4  shared bus byte enables.
- bus_addr_o  out  32  shared bus address.
- bus_wdata_o  out  32  shared bus write data.
- bus_gnt_i  in  1  shared bus grant.
- bus_rvalid_i  in  1  shared bus response valid.
- bus_rdata_i  in  32  shared bus response data.
- bus_err_i  in  1  shared bus error.
- busy_o  out  1  request pending or transaction outstanding.
- protocol_err_o  out  1  sticky flag: response arrived with nothing outstanding.

Behaviour:
- Reset:
  - state ARB, outstanding count 0, round-robin pointer favours instr, protocol_err_o 0.
  - While rst_i is high, all gnt/rvalid/bus_req_o/busy_o outputs are 0.
- State ARB:
  - If count < MaxOutstanding, select a requester. If only one requests, select it.
  - If both request: with DataPriority=1, select data. With DataPriority=0, select the port not granted last.
  - bus_req_o = selected req. Bus address-phase fields are muxed from the selected port.
  - A fetch drives bus_we_o=0, bus_be_o=4'hF, bus_wdata_o=0.
  - If count == MaxOutstanding, bus_req_o=0 even when a pop happens in the same cycle.
- Transition ARB->LOCK: bus_req_o & ~bus_gnt_i; record the selected owner.
- State LOCK:
  - Selection is forced to the recorded owner and the other port is ignored.
  - bus_req_o = owner's req.
  - Exit to ARB on bus_gnt_i.
  - If the owner drops req before grant, exit to ARB; no transaction is recorded.
- Grant:
  - Granted port's gnt_o = bus_gnt_i & bus_req_o, combinational (0 cycles).
  - The grant pushes the owner ID into the outstanding FIFO and updates the round-robin pointer to the granted port.
- Response:
  - bus_rvalid_i pops the FIFO head. rvalid_o is asserted combinationally on the head owner's port only.
  - rdata_o of both ports = bus_rdata_i. err_o = bus_err_i & the port's rvalid_o.
- Simultaneous push and pop: count unchanged; FIFO order preserved.
- Stray response: bus_rvalid_i with count == 0 is not routed (no port rvalid) and sets protocol_err_o until reset.
- busy_o = (count != 0) | bus_req_o.
- Reset mid-operation: outstanding IDs are discarded. Any response to a pre-reset grant is treated as stray.
- Throughput:
  - One grant per cycle is possible, back-to-back.
  - Fetch sees its gnt in the same cycle the bus grants, so the prefetch path's 2-outstanding pipelining is preserved when MaxOutstanding >= 2.

Decomposition:
- Shared package ibex_pkg:
  - owner_e enum {OWNER_INSTR=1'b0, OWNER_DATA=1'b1}.
  - arb_state_e enum {ARB_IDLE, ARB_LOCK}.
- One sub-module, ibex_bus_owner_fifo:
  - 1-bit-wide circular FIFO of depth MaxOutstanding.
  - Ports: push, pop, head, count, full, empty.
  - Pointer wrap at MaxOutstanding, including non-power-of-two depths.

Test Plan:
1. Fetch only: instr_req_i=1, addr 0x80, bus_gnt_i=1 every cycle, rvalid 1 cycle later -> instr_gnt_o the same cycle; after 2 grants with no rvalid, bus_req_o=0 (full at 2); instr_rvalid_o follows each rvalid in order.
2. Contention with DataPriority=1: both request in the same cycle, addr 0x100 (data) / 0x200 (instr), gnt=1 -> bus_addr_o=0x100, data_gnt_o=1, instr_gnt_o=0; next cycle 0x200 granted to instr.
3. Lock: instr request, gnt=0 for 3 cycles, data_req_i rises in cycle 2 -> bus_addr_o stays at the instr address until gnt; data is served after.
4. Response routing: grant order instr, data, rvalid with err=1 on the second -> instr_rvalid_o then data_rvalid_o with data_err_o=1; instr_err_o stays 0.
5. Round-robin (DataPriority=0): both requesting continuously, gnt=1, rvalid every cycle -> grants alternate instr, data, instr, data.
6. Stray/reset: rst_i pulsed with 1 outstanding, then bus_rvalid_i=1 -> no port rvalid, protocol_err_o=1 until the next rst_i.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types for the instruction-fetch / LSU bus arbiter.
package ibex_pkg;

  // Identifies which requester issued a bus transaction.
  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Address-phase arbitration state: free to choose, or held until granted.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // A fetch always reads a whole word.
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/ibex_bus_owner_fifo.sv
// Circular FIFO of owner IDs, one entry per granted-but-unanswered bus
// transaction. Depth need not be a power of two.
module ibex_bus_owner_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  owner_e                       push_owner_i,
  input  logic                         pop_i,
  output owner_e                       head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  owner_e          mem_q [Depth];
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Wrap explicitly at Depth-1 so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and occupancy; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Owner storage.
  // NOTE: the storage array is not reset; count gates every read, so stale entries are never used.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_owner_i;
  end

endmodule

// File: rtl/ibex_ifetch_bus_arbiter.sv
// Shares one OBI-style bus between the instruction prefetcher and the LSU.
// An address-phase selection is held until granted, and every grant records
// its owner so the in-order responses are routed back to the right port.
module ibex_ifetch_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;   // port holding the lock
  owner_e          last_q, last_d;     // port granted most recently
  logic            perr_q, perr_d;
  owner_e          sel;
  logic            sel_req;
  owner_e          head;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            gnt_acc, rsp_pop, stray;

  // Pick the address-phase owner: locked owner, or arbitrate between both ports.
  always_comb begin
    sel     = OWNER_INSTR;
    sel_req = 1'b0;
    if (state_q == ARB_LOCK) begin
      sel     = owner_q;
      sel_req = (owner_q == OWNER_DATA) ? data_req_i : instr_req_i;
    end else begin
      sel_req = instr_req_i | data_req_i;
      if (instr_req_i && data_req_i) begin
        if (DataPriority) sel = OWNER_DATA;
        else              sel = (last_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
      end else if (data_req_i) begin
        sel = OWNER_DATA;
      end
    end
  end

  // No new request once the response tracker is full, even if it pops this cycle.
  assign bus_req_o = sel_req & ~full & ~rst_i;
  assign gnt_acc   = bus_req_o & bus_gnt_i;

  // Address-phase fields follow the selected port; a fetch is a full-word read.
  always_comb begin
    if (sel == OWNER_DATA) begin
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_addr_o  = data_addr_i;
      bus_wdata_o = data_wdata_i;
    end else begin
      bus_we_o    = 1'b0;
      bus_be_o    = FETCH_BE;
      bus_addr_o  = instr_addr_i;
      bus_wdata_o = '0;
    end
  end

  assign instr_gnt_o = gnt_acc & (sel == OWNER_INSTR);
  assign data_gnt_o  = gnt_acc & (sel == OWNER_DATA);

  // Responses come back in grant order; the FIFO head names their owner.
  assign rsp_pop        = bus_rvalid_i & ~empty;
  assign stray          = bus_rvalid_i & empty;
  assign instr_rvalid_o = rsp_pop & (head == OWNER_INSTR);
  assign data_rvalid_o  = rsp_pop & (head == OWNER_DATA);
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign instr_err_o    = bus_err_i & instr_rvalid_o;
  assign data_err_o     = bus_err_i & data_rvalid_o;

  assign busy_o         = (count != '0) | bus_req_o;
  assign protocol_err_o = perr_q;

  ibex_bus_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (gnt_acc),
    .push_owner_i (sel),
    .pop_i        (rsp_pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Lock/arbitrate transitions, round-robin history and the sticky stray flag.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    perr_d  = perr_q | stray;
    case (state_q)
      ARB_IDLE: begin
        if (bus_req_o && !bus_gnt_i) begin
          state_d = ARB_LOCK;
          owner_d = sel;
        end
      end
      ARB_LOCK: begin
        // Leave on grant, or when the owner withdraws before being granted.
        if (!sel_req || bus_gnt_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (gnt_acc) last_d = sel;
  end

  // Arbiter state registers; after reset round-robin favours the fetch port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_INSTR;
      last_q  <= OWNER_DATA;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_ibex_ifetch_bus_arbiter.sv
// Scoreboard bench for ibex_ifetch_bus_arbiter: instance u_dut uses data
// priority, u_rr uses round-robin. Expected grants and responses are queued
// by the stimulus and consumed by per-instance monitors on the falling edge.
module tb_ibex_ifetch_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance A (DataPriority = 1) ----------------
  logic        a_instr_req = 1'b0;
  logic [31:0] a_instr_addr = '0;
  logic        a_instr_gnt, a_instr_rvalid, a_instr_err;
  logic [31:0] a_instr_rdata;
  logic        a_data_req = 1'b0, a_data_we = 1'b0;
  logic [3:0]  a_data_be = 4'hF;
  logic [31:0] a_data_addr = '0, a_data_wdata = '0;
  logic        a_data_gnt, a_data_rvalid, a_data_err;
  logic [31:0] a_data_rdata;
  logic        a_bus_req, a_bus_we;
  logic [3:0]  a_bus_be;
  logic [31:0] a_bus_addr, a_bus_wdata;
  logic        a_bus_gnt = 1'b0, a_bus_rvalid = 1'b0, a_bus_err = 1'b0;
  logic [31:0] a_bus_rdata = '0;
  logic        a_busy, a_perr;

  // ---------------- instance B (DataPriority = 0) ----------------
  logic        b_instr_req = 1'b0;
  logic [31:0] b_instr_addr = '0;
  logic        b_instr_gnt, b_instr_rvalid, b_instr_err;
  logic [31:0] b_instr_rdata;
  logic        b_data_req = 1'b0, b_data_we = 1'b0;
  logic [3:0]  b_data_be = 4'hF;
  logic [31:0] b_data_addr = '0, b_data_wdata = '0;
  logic        b_data_gnt, b_data_rvalid, b_data_err;
  logic [31:0] b_data_rdata;
  logic        b_bus_req, b_bus_we;
  logic [3:0]  b_bus_be;
  logic [31:0] b_bus_addr, b_bus_wdata;
  logic        b_bus_gnt = 1'b0, b_bus_rvalid = 1'b0, b_bus_err = 1'b0;
  logic [31:0] b_bus_rdata = '0;
  logic        b_busy, b_perr;

  ibex_ifetch_bus_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(a_instr_req), .instr_addr_i(a_instr_addr), .instr_gnt_o(a_instr_gnt),
    .instr_rvalid_o(a_instr_rvalid), .instr_rdata_o(a_instr_rdata), .instr_err_o(a_instr_err),
    .data_req_i(a_data_req), .data_we_i(a_data_we), .data_be_i(a_data_be),
    .data_addr_i(a_data_addr), .data_wdata_i(a_data_wdata), .data_gnt_o(a_data_gnt),
    .data_rvalid_o(a_data_rvalid), .data_rdata_o(a_data_rdata), .data_err_o(a_data_err),
    .bus_req_o(a_bus_req), .bus_we_o(a_bus_we), .bus_be_o(a_bus_be),
    .bus_addr_o(a_bus_addr), .bus_wdata_o(a_bus_wdata), .bus_gnt_i(a_bus_gnt),
    .bus_rvalid_i(a_bus_rvalid), .bus_rdata_i(a_bus_rdata), .bus_err_i(a_bus_err),
    .busy_o(a_busy), .protocol_err_o(a_perr)
  );

  ibex_ifetch_bus_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(b_instr_req), .instr_addr_i(b_instr_addr), .instr_gnt_o(b_instr_gnt),
    .instr_rvalid_o(b_instr_rvalid), .instr_rdata_o(b_instr_rdata), .instr_err_o(b_instr_err),
    .data_req_i(b_data_req), .data_we_i(b_data_we), .data_be_i(b_data_be),
    .data_addr_i(b_data_addr), .data_wdata_i(b_data_wdata), .data_gnt_o(b_data_gnt),
    .data_rvalid_o(b_data_rvalid), .data_rdata_o(b_data_rdata), .data_err_o(b_data_err),
    .bus_req_o(b_bus_req), .bus_we_o(b_bus_we), .bus_be_o(b_bus_be),
    .bus_addr_o(b_bus_addr), .bus_wdata_o(b_bus_wdata), .bus_gnt_i(b_bus_gnt),
    .bus_rvalid_i(b_bus_rvalid), .bus_rdata_i(b_bus_rdata), .bus_err_i(b_bus_err),
    .busy_o(b_busy), .protocol_err_o(b_perr)
  );

  // Expected grants {instr_gnt, data_gnt, addr} and responses
  // {instr_rvalid, data_rvalid, instr_err, data_err, rdata}.
  logic [33:0] a_gnt_q[$], b_gnt_q[$];
  logic [35:0] a_rsp_q[$], b_rsp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void exp_gnt(input bit on_b, input logic d, input logic [31:0] addr);
    if (on_b) b_gnt_q.push_back({~d, d, addr});
    else      a_gnt_q.push_back({~d, d, addr});
  endfunction

  function automatic void exp_rsp(input bit on_b, input logic d, input logic err,
                                  input logic [31:0] data);
    if (on_b) b_rsp_q.push_back({~d, d, ~d & err, d & err, data});
    else      a_rsp_q.push_back({~d, d, ~d & err, d & err, data});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_instr_req = 1'b0; a_data_req = 1'b0; a_bus_gnt = 1'b0;
    a_bus_rvalid = 1'b0; a_bus_err = 1'b0;
  endtask

  // Monitor A: every grant / response must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_instr_gnt || a_data_gnt) begin
        if (a_gnt_q.size() == 0) check("a_unexpected_gnt", 64'({a_instr_gnt, a_data_gnt}), 64'h0);
        else check("a_gnt", 64'({a_instr_gnt, a_data_gnt, a_bus_addr}), 64'(a_gnt_q.pop_front()));
      end
      if (a_instr_rvalid || a_data_rvalid) begin
        if (a_rsp_q.size() == 0) check("a_unexpected_rsp", 64'({a_instr_rvalid, a_data_rvalid}), 64'h0);
        else check("a_rsp", 64'({a_instr_rvalid, a_data_rvalid, a_instr_err, a_data_err,
                                 a_instr_rvalid ? a_instr_rdata : a_data_rdata}),
                   64'(a_rsp_q.pop_front()));
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (!rst) begin
      if (b_instr_gnt || b_data_gnt) begin
        if (b_gnt_q.size() == 0) check("b_unexpected_gnt", 64'({b_instr_gnt, b_data_gnt}), 64'h0);
        else check("b_gnt", 64'({b_instr_gnt, b_data_gnt, b_bus_addr}), 64'(b_gnt_q.pop_front()));
      end
      if (b_instr_rvalid || b_data_rvalid) begin
        if (b_rsp_q.size() == 0) check("b_unexpected_rsp", 64'({b_instr_rvalid, b_data_rvalid}), 64'h0);
        else check("b_rsp", 64'({b_instr_rvalid, b_data_rvalid, b_instr_err, b_data_err,
                                 b_instr_rvalid ? b_instr_rdata : b_data_rdata}),
                   64'(b_rsp_q.pop_front()));
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    // Reset: outputs held low even with a request and a grant present.
    a_instr_req = 1'b1; a_instr_addr = 32'h80; a_bus_gnt = 1'b1;
    @(negedge clk);
    check("rst_outputs", 64'({a_bus_req, a_instr_gnt, a_data_gnt, a_busy, a_perr, a_instr_rvalid}), 64'h0);
    tick();
    rst = 1'b0;

    // 1. Fetch only: two back-to-back grants, then full.
    exp_gnt(0, 1'b0, 32'h80); tick();
    exp_gnt(0, 1'b0, 32'h80); tick();
    a_bus_rvalid = 1'b1; a_bus_rdata = 32'hA1; exp_rsp(0, 1'b0, 1'b0, 32'hA1);
    @(negedge clk); check("t1_full_no_req", 64'(a_bus_req), 64'h0);
    tick();
    a_bus_rdata = 32'hA2; exp_rsp(0, 1'b0, 1'b0, 32'hA2); exp_gnt(0, 1'b0, 32'h80); tick();
    a_instr_req = 1'b0; a_bus_rdata = 32'hA3; exp_rsp(0, 1'b0, 1'b0, 32'hA3); tick();
    idle_a();
    @(negedge clk); check("t1_idle_busy", 64'({a_busy, a_bus_req}), 64'h0);
    tick();

    // 2. Contention with data priority.
    a_instr_req = 1'b1; a_instr_addr = 32'h200;
    a_data_req = 1'b1; a_data_addr = 32'h100; a_data_we = 1'b1; a_data_be = 4'h3;
    a_data_wdata = 32'hDEADBEEF; a_bus_gnt = 1'b1;
    exp_gnt(0, 1'b1, 32'h100);
    @(negedge clk); check("t2_data_fields", 64'({a_bus_we, a_bus_be, a_bus_wdata}), 64'h1_3_DEADBEEF);
    tick();
    a_data_req = 1'b0; exp_gnt(0, 1'b0, 32'h200);
    @(negedge clk); check("t2_fetch_fields", 64'({a_bus_we, a_bus_be, a_bus_wdata}), 64'h0_F_00000000);
    tick();
    idle_a(); a_data_we = 1'b0; a_data_be = 4'hF; a_data_wdata = '0;
    a_bus_rvalid = 1'b1; a_bus_rdata = 32'h11; exp_rsp(0, 1'b1, 1'b0, 32'h11); tick();
    a_bus_rdata = 32'h22; exp_rsp(0, 1'b0, 1'b0, 32'h22); tick();
    idle_a(); tick();

    // 3. Lock: selection held on the fetch until granted.
    a_instr_req = 1'b1; a_instr_addr = 32'h300;
    @(negedge clk); check("t3_lock_c0", 64'(a_bus_addr), 64'h300);
    tick();
    a_data_req = 1'b1; a_data_addr = 32'h400;
    @(negedge clk); check("t3_lock_c1", 64'(a_bus_addr), 64'h300);
    tick();
    @(negedge clk); check("t3_lock_c2", 64'(a_bus_addr), 64'h300);
    tick();
    a_bus_gnt = 1'b1; exp_gnt(0, 1'b0, 32'h300); tick();
    a_instr_req = 1'b0; exp_gnt(0, 1'b1, 32'h400); tick();
    idle_a(); a_bus_rvalid = 1'b1; a_bus_rdata = 32'h33; exp_rsp(0, 1'b0, 1'b0, 32'h33); tick();
    a_bus_rdata = 32'h44; exp_rsp(0, 1'b1, 1'b0, 32'h44); tick();
    idle_a(); tick();

    // 3b. Lock owner withdraws: the other port is ignored that cycle.
    a_instr_req = 1'b1; a_instr_addr = 32'h500; tick();
    a_instr_req = 1'b0; a_data_req = 1'b1; a_data_addr = 32'h600; a_bus_gnt = 1'b1;
    @(negedge clk); check("t3_drop_no_req", 64'(a_bus_req), 64'h0);
    tick();
    exp_gnt(0, 1'b1, 32'h600); tick();
    idle_a(); a_bus_rvalid = 1'b1; a_bus_rdata = 32'h55; exp_rsp(0, 1'b1, 1'b0, 32'h55); tick();
    idle_a(); tick();

    // 4. Response routing with an error on the data response.
    a_instr_req = 1'b1; a_instr_addr = 32'h700; a_bus_gnt = 1'b1; exp_gnt(0, 1'b0, 32'h700); tick();
    a_instr_req = 1'b0; a_data_req = 1'b1; a_data_addr = 32'h800; exp_gnt(0, 1'b1, 32'h800); tick();
    idle_a(); a_bus_rvalid = 1'b1; a_bus_rdata = 32'h66; exp_rsp(0, 1'b0, 1'b0, 32'h66); tick();
    a_bus_rdata = 32'h77; a_bus_err = 1'b1; exp_rsp(0, 1'b1, 1'b1, 32'h77);
    @(negedge clk); check("t4_instr_err_low", 64'(a_instr_err), 64'h0);
    tick();
    idle_a(); tick();

    // 6. Reset with one transaction outstanding, then a stray response.
    @(negedge clk); check("t6_perr_before", 64'(a_perr), 64'h0);
    tick();
    a_instr_req = 1'b1; a_instr_addr = 32'h900; a_bus_gnt = 1'b1; exp_gnt(0, 1'b0, 32'h900); tick();
    idle_a(); rst = 1'b1;
    @(negedge clk); check("t6_rst_busy", 64'({a_busy, a_bus_req}), 64'h0);
    tick();
    rst = 1'b0; tick();
    a_bus_rvalid = 1'b1; a_bus_rdata = 32'h99;
    @(negedge clk); check("t6_stray_unrouted", 64'({a_instr_rvalid, a_data_rvalid}), 64'h0);
    tick();
    idle_a();
    @(negedge clk); check("t6_perr_set", 64'(a_perr), 64'h1);
    tick(); tick();
    @(negedge clk); check("t6_perr_sticky", 64'(a_perr), 64'h1);
    tick();
    rst = 1'b1;
    @(negedge clk); check("t6_perr_cleared", 64'(a_perr), 64'h0);
    tick();
    rst = 1'b0; tick();

    // 5. Round-robin instance: continuous contention, one response per cycle.
    b_instr_req = 1'b1; b_instr_addr = 32'hA00;
    b_data_req = 1'b1; b_data_addr = 32'hB00; b_data_we = 1'b1; b_data_be = 4'hC;
    b_data_wdata = 32'h12345678; b_bus_gnt = 1'b1;
    exp_gnt(1, 1'b0, 32'hA00);
    @(negedge clk); check("t5_first_addr", 64'(b_bus_addr), 64'hA00);
    tick();
    b_bus_rvalid = 1'b1; b_bus_rdata = 32'hC1;
    exp_rsp(1, 1'b0, 1'b0, 32'hC1); exp_gnt(1, 1'b1, 32'hB00);
    @(negedge clk); check("t5_data_fields", 64'({b_bus_we, b_bus_be, b_bus_wdata}), 64'h1_C_12345678);
    tick();
    b_bus_rdata = 32'hC2; exp_rsp(1, 1'b1, 1'b0, 32'hC2); exp_gnt(1, 1'b0, 32'hA00); tick();
    b_bus_rdata = 32'hC3; exp_rsp(1, 1'b0, 1'b0, 32'hC3); exp_gnt(1, 1'b1, 32'hB00); tick();
    b_instr_req = 1'b0; b_data_req = 1'b0; b_bus_gnt = 1'b0;
    b_bus_rdata = 32'hC4; exp_rsp(1, 1'b1, 1'b0, 32'hC4); tick();
    b_bus_rvalid = 1'b0;
    @(negedge clk); check("t5_idle", 64'({b_busy, b_bus_req, b_perr}), 64'h0);
    tick();

    // Every queued expectation must have been consumed.
    check("a_gnt_left", 64'(a_gnt_q.size()), 64'h0);
    check("a_rsp_left", 64'(a_rsp_q.size()), 64'h0);
    check("b_gnt_left", 64'(b_gnt_q.size()), 64'h0);
    check("b_rsp_left", 64'(b_rsp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
